// File: rtl/io_request_bridge.sv
// io_request_bridge
//   Sequencer between the CPU memory port and the IO-mapped device block.
//   Accepts one request at a time (valid/ready). It drives the IO address,
//   control and data lines for exactly one cycle. For reads it waits out the IO
//   block's register pipeline, then returns the read word with a one-cycle
//   response pulse.
//
//   Optional build macro: IO_BRIDGE_VRAM_GUARD_EN. When it is defined, byte
//   writes to VRAM (addr[25:23]==1) are rejected with resp_error.
//
// Ports
//   main_clk, main_rst_n        clock, async active-low reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_address/write/byte/data request payload
//   resp_valid/resp_data/error  one-cycle completion pulse + read data / error
//   io_address/control/data_out to IO block, non-zero only during ISSUE
//   io_data_in                  read data from IO block
module io_request_bridge #(
  parameter int READ_WAIT = 2
) (
  input  logic        main_clk,
  input  logic        main_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_address,
  input  logic        req_write,
  input  logic        req_byte,
  input  logic [15:0] req_data,
  output logic        resp_valid,
  output logic [15:0] resp_data,
  output logic        resp_error,
  output logic [31:0] io_address,
  output logic [1:0]  io_control,
  output logic [15:0] io_data_out,
  input  logic [15:0] io_data_in
);

  localparam int CW = (READ_WAIT > 2) ? $clog2(READ_WAIT - 1) : 1;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           wr_q, wr_d;
  // Low while reset is asserted and in the clock edge that ends it. This keeps
  // req_ready at 0 during reset even though the state register already reads
  // IDLE.
  logic           live_q;

  logic [31:0]    io_address_q, io_address_d;
  logic [1:0]     io_control_q, io_control_d;
  logic [15:0]    io_data_out_q, io_data_out_d;
  logic           resp_valid_q, resp_valid_d;
  logic           resp_error_q, resp_error_d;
  logic [15:0]    resp_data_q, resp_data_d;

  logic           accept;
  logic           req_err;

  assign req_ready = (state_q == IDLE) && live_q;
  assign accept    = req_valid && req_ready;

  // Reject anything outside IO space. The guard build also rejects byte
  // writes to VRAM.
  always_comb begin
    req_err = !req_address[31];
`ifdef IO_BRIDGE_VRAM_GUARD_EN
    if (req_write && req_byte && (req_address[25:23] == 3'd1)) req_err = 1'b1;
`endif
  end

  // State register
  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      live_q  <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          wr_d    = req_write;
          state_d = req_err ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = '0;
        if (wr_q)               state_d = RESP;
        else if (READ_WAIT > 1) state_d = WAIT;
        else                    state_d = CAPTURE;
      end
      WAIT: begin
        if (cnt_q == CW'(READ_WAIT - 2)) state_d = CAPTURE;
        else                             cnt_d   = cnt_q + 1'b1;
      end
      CAPTURE: state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic. Every output except req_ready is registered. The io_*
  // registers load the request on the accept edge, so they hold the latched
  // address, control and data during ISSUE and read zero in every other state.
  always_comb begin
    io_address_d  = '0;
    io_control_d  = '0;
    io_data_out_d = '0;
    if (accept && !req_err) begin
      io_address_d  = req_address;
      io_control_d  = {req_write, req_byte};
      io_data_out_d = req_byte ? {8'h00, req_data[7:0]} : req_data;
    end
    resp_valid_d = (state_d == RESP);
    resp_error_d = accept && req_err;
    // Byte-read data is already lane-selected by the IO block. It is passed
    // through unmodified.
    resp_data_d  = (state_q == CAPTURE) ? io_data_in : 16'h0000;
  end

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      io_address_q  <= '0;
      io_control_q  <= '0;
      io_data_out_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_data_q   <= '0;
    end else begin
      io_address_q  <= io_address_d;
      io_control_q  <= io_control_d;
      io_data_out_q <= io_data_out_d;
      resp_valid_q  <= resp_valid_d;
      resp_error_q  <= resp_error_d;
      resp_data_q   <= resp_data_d;
    end
  end

  assign io_address  = io_address_q;
  assign io_control  = io_control_q;
  assign io_data_out = io_data_out_q;
  assign resp_valid  = resp_valid_q;
  assign resp_error  = resp_error_q;
  assign resp_data   = resp_data_q;

endmodule

// File: tb/tb_io_request_bridge.sv
// Scoreboard bench for io_request_bridge. Requests push the expected
// {error, data} response. A monitor pops and compares each resp_valid pulse.
// The request task also checks the per-cycle io_* and timing behaviour and
// plays the IO block, which presents read data only in the capture cycle.
module tb_io_request_bridge;

  logic        main_clk, main_rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_address;
  logic        req_write, req_byte;
  logic [15:0] req_data;
  logic        resp_valid, resp_error;
  logic [15:0] resp_data;
  logic [31:0] io_address;
  logic [1:0]  io_control;
  logic [15:0] io_data_out, io_data_in;

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] sb_q[$];

  io_request_bridge #(.READ_WAIT(2)) dut (
    .main_clk(main_clk), .main_rst_n(main_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .req_write(req_write), .req_byte(req_byte),
    .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_error(resp_error),
    .io_address(io_address), .io_control(io_control),
    .io_data_out(io_data_out), .io_data_in(io_data_in)
  );

  initial begin
    main_clk = 1'b0;
    forever #5 main_clk = ~main_clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_err_f(input logic [31:0] a, input logic wr, input logic byt);
    logic e;
    e = !a[31];
`ifdef IO_BRIDGE_VRAM_GUARD_EN
    if (wr && byt && a[25:23] == 3'd1) e = 1'b1;
`endif
    return e;
  endfunction

  // Response monitor. It pops the scoreboard on every resp_valid pulse.
  always @(negedge main_clk) begin
    if (main_rst_n && resp_valid) begin
      if (sb_q.size() == 0) chk("sb_extra", {31'b0, resp_valid}, 32'h0);
      else begin
        logic [16:0] e;
        e = sb_q.pop_front();
        chk("rdata", {16'h0, resp_data}, {16'h0, e[15:0]});
        chk("rerr", {31'b0, resp_error}, {31'b0, e[16]});
      end
    end
  end

  // One request, accepted in cycle N. It checks io_* and resp_valid at every
  // negedge up to the response cycle.
  task automatic do_req(input logic [31:0] a, input logic wr, input logic byt,
                        input logic [15:0] d, input logic [15:0] ret, input logic err);
    int n = 0;
    int rk;
    logic iss;
    @(negedge main_clk);
    while (!req_ready && n < 20) begin @(negedge main_clk); n++; end
    chk("ready", {31'b0, req_ready}, 32'h1);
    req_address = a; req_write = wr; req_byte = byt; req_data = d; req_valid = 1'b1;
    sb_q.push_back({err, (wr || err) ? 16'h0000 : ret});
    rk = err ? 1 : (wr ? 2 : 4);
    for (int k = 1; k <= rk; k++) begin
      @(negedge main_clk);
      // The bridge must ignore req_* after accept. Present a non-IO request.
      req_valid = (k == 1); req_address = 32'h0; req_write = 1'b0;
      if (k > 1) req_valid = 1'b0;
      iss = (k == 1) && !err;
      chk("io_addr", io_address, iss ? a : 32'h0);
      chk("io_ctl", {30'b0, io_control}, iss ? {30'b0, wr, byt} : 32'h0);
      chk("io_dout", {16'h0, io_data_out},
          iss ? {16'h0, (byt ? {8'h00, d[7:0]} : d)} : 32'h0);
      chk("resp_v", {31'b0, resp_valid}, {31'b0, (k == rk)});
      chk("rdy_busy", {31'b0, req_ready}, 32'h0);
      io_data_in = (k == 3) ? ret : 16'hDEAD;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [15:0] d, r;
    logic        wr, byt;
    main_rst_n = 1'b0; req_valid = 1'b0; req_address = '0; req_write = 1'b0;
    req_byte = 1'b0; req_data = '0; io_data_in = 16'hDEAD;
    #12;
    chk("rst_rdy", {31'b0, req_ready}, 32'h0);
    chk("rst_rv", {31'b0, resp_valid}, 32'h0);
    chk("rst_addr", io_address, 32'h0);
    @(negedge main_clk);
    @(negedge main_clk);
    main_rst_n = 1'b1;
    @(negedge main_clk);
    chk("rdy_after_rst", {31'b0, req_ready}, 32'h1);

    do_req(32'h8000_0003, 1'b1, 1'b0, 16'h0001, 16'h0, 1'b0);       // LED write
    do_req(32'h8100_0000, 1'b0, 1'b0, 16'h0000, 16'hBEEF, 1'b0);    // SD read
    do_req(32'h8180_0001, 1'b1, 1'b1, 16'hA55A, 16'h0, 1'b0);       // byte write
    do_req(32'h0000_1000, 1'b0, 1'b0, 16'h0000, 16'h1111, 1'b1);    // non-IO read
    do_req(32'h0000_2000, 1'b1, 1'b0, 16'h7777, 16'h0, 1'b1);       // non-IO write
    do_req(32'h8080_0000, 1'b1, 1'b1, 16'h1234, 16'h0,
           exp_err_f(32'h8080_0000, 1'b1, 1'b1));                   // VRAM guard
    do_req(32'h8080_0000, 1'b1, 1'b0, 16'h4321, 16'h0, 1'b0);       // VRAM word write
    do_req(32'h8080_0002, 1'b0, 1'b1, 16'h0000, 16'h00C3, 1'b0);    // byte read

    // Reset during the WAIT state of a read.
    @(negedge main_clk);
    req_address = 32'h8100_0004; req_write = 1'b0; req_byte = 1'b0; req_valid = 1'b1;
    @(negedge main_clk);
    req_valid = 1'b0;
    chk("rr_issue", io_address, 32'h8100_0004);
    @(negedge main_clk);
    #2 main_rst_n = 1'b0;
    #1;
    chk("rr_addr", io_address, 32'h0);
    chk("rr_rv", {31'b0, resp_valid}, 32'h0);
    chk("rr_rdy", {31'b0, req_ready}, 32'h0);
    @(negedge main_clk);
    @(negedge main_clk);
    main_rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge main_clk);
      chk("rr_no_resp", {31'b0, resp_valid}, 32'h0);
    end
    do_req(32'h8000_0010, 1'b0, 1'b0, 16'h0000, 16'h1357, 1'b0);

    // Back-to-back requests with random payloads.
    for (int i = 0; i < 8; i++) begin
      a = $urandom; d = 16'($urandom); r = 16'($urandom);
      wr = 1'($urandom_range(0, 1)); byt = 1'($urandom_range(0, 1));
      if (i % 4 != 3) a[31] = 1'b1;
      if (byt && !wr) r = {8'h00, r[7:0]};
      do_req(a, wr, byt, d, r, exp_err_f(a, wr, byt));
    end

    @(negedge main_clk);
    @(negedge main_clk);
    chk("sb_left", sb_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/io_request_bridge.md
# io_request_bridge

Sequencer between the CPU memory port and the IO-mapped device block (LEDs, VRAM, SD card controller, PS/2 controller). Accepts one IO request at a time over a valid/ready handshake. Drives the IO address, control and data lines for exactly one cycle. For reads, waits out the IO block's two-register output pipeline, captures the read word and returns it with a one-cycle response pulse.

## Interface
Parameters:
- READ_WAIT, 2, cycles between the issue cycle and the cycle in which `io_data_in` is sampled. Matches the IO block's two address/control register stages.

Ports:
- main_clk  in  1  sole clock.
- main_rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  bridge can accept. High only in IDLE.
- req_address  in  32  byte address. Bit 31 must be 1 (IO space).
- req_write  in  1  1 = write, 0 = read.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_data  in  16  write data. For byte writes, only [7:0] is used.
- resp_valid  out  1  one-cycle completion pulse.
- resp_data  out  16  read data. 0 for writes and errors.
- resp_error  out  1  qualified by resp_valid. Request rejected, nothing issued.
- io_address  out  32  to IO block `address_io`.
- io_control  out  2  to IO block `control_io`, as {write, byte}.
- io_data_out  out  16  to IO block `data_in_io`.
- io_data_in  in  16  from IO block `data_out_io`.

## Operation
States: IDLE, ISSUE, WAIT, CAPTURE, RESP.
- IDLE
  - req_ready=1.
  - On req_valid: latch address, write, byte and data.
  - If req_address[31]==0: go to RESP with error.
  - Otherwise: go to ISSUE.
- ISSUE (exactly 1 cycle)
  - io_address = latched address.
  - io_control = {write, byte}.
  - io_data_out = byte ? {8'h0, data[7:0]} : data.
  - Write: go to RESP. Read: go to WAIT.
- WAIT: counts READ_WAIT-1 cycles, then goes to CAPTURE.
- CAPTURE: register io_data_in into the response register, then go to RESP.
- RESP: resp_valid=1 for one cycle, then go to IDLE.

Common rules:
- In every state other than ISSUE: io_address=0, io_control=0, io_data_out=0. Address bit 31 = 0 means no device reacts.
- Byte read data arrives already zero-extended and lane-selected from the IO block. It is passed through unmodified.
- Writes never sample io_data_in. resp_data=0 for writes.
- req_* inputs are ignored outside IDLE. Requesters must hold them until the req_valid&&req_ready cycle.

## Timing
- Accept at cycle N (IDLE).
- ISSUE at N+1.
- Write: resp_valid at N+2.
- Read: WAIT covers N+2, CAPTURE samples io_data_in at N+3, resp_valid with data at N+4.
- Error: resp_valid=1 with resp_error=1 at N+1. io_* stay 0 throughout.
- Maximum throughput: one write per 3 cycles, one read per 5 cycles. req_ready returns high in the cycle after RESP.
- Reset (asynchronous assert, any state):
  - State goes to IDLE; all outputs drop to 0 immediately.
  - An in-flight request is dropped with no response.
  - req_ready rises in the first cycle after deassertion.
- All outputs except req_ready are driven from registers. req_ready is decoded from the state register only.

## Configuration
- IO_BRIDGE_VRAM_GUARD_EN defined: a byte write with req_address[25:23]==3'd1 (VRAM) is rejected like a non-IO address. The response is resp_error=1 at N+1 and nothing is issued.
- IO_BRIDGE_VRAM_GUARD_EN undefined: the request is issued normally and the VRAM silently ignores it.

## Test plan
- LED write: req 0x8000_0003, write, word, data 0x0001 -> at N+1, io_address=0x8000_0003 and io_control=2'b10; resp_valid at N+2 with resp_data=0 and resp_error=0.
- Read: req 0x8100_0000 (SD, address bits [25:23]=2), word read; model returns 0xBEEF at N+3 -> resp_valid at N+4 with resp_data=0xBEEF; io_* are 0 at N+2..N+4.
- Byte write: req 0x8180_0001, byte, data 0xA55A -> io_data_out=0x005A and io_control=2'b11 during ISSUE only.
- Non-IO address: req 0x0000_1000 -> resp_error=1 at N+1; io_control stays 0 for all cycles.
- Guard: byte write to 0x8080_0000 -> error with IO_BRIDGE_VRAM_GUARD_EN defined; issued normally with it undefined.
- Reset asserted during WAIT of a read -> outputs 0 immediately; no resp_valid after release; the next request completes normally.
